// File: rtl/drum_pkg.sv
// Shared definitions for the DRUM approximate multiplier datapath:
// default operand/mantissa widths, the shift-amount width rule and the
// per-operand truncation result record.
package drum_pkg;

    localparam int N_DEF = 8;
    localparam int K_DEF = 4;

    // Shift amounts range over 0..N-K, so this many bits are needed to hold one.
    function automatic int sh_width(input int n, input int k);
        return $clog2(n - k + 1);
    endfunction

    localparam int SW_DEF = sh_width(N_DEF, K_DEF);

    // Truncated operand as consumed by the multiplier core and restored by
    // the output shifter (default-width configuration).
    typedef struct packed {
        logic [K_DEF-1:0]  m;
        logic [SW_DEF-1:0] sh;
        logic              zero;
    } drum_res_t;

endpackage

// File: rtl/drum_lod.sv
// Combinational leading-one detector: index of the highest set bit of a,
// plus a flag for the all-zero operand (p is 0 in that case).
module drum_lod #(
    parameter  int N  = 8,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  a,
    output logic [PW-1:0] p,
    output logic          zero
);

    // Scan upward so the last set bit seen is the most significant one.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        p    = '0;
        zero = (a == '0);
        for (int i = 0; i < N; i++) begin
            if (a[i]) begin
                p = PW'(i);
            end
        end
    end

endmodule

// File: rtl/drum_operand_truncator.sv
// Two-stage valid/ready pipeline that reduces an N-bit unsigned operand to a
// K-bit mantissa (LSB forced to 1 when truncated) and the right-shift amount
// the output stage must later undo. Stage 1 locates the leading one, stage 2
// shifts and registers the result.
module drum_operand_truncator
    import drum_pkg::*;
#(
    parameter  int N  = N_DEF,
    parameter  int K  = K_DEF,
    localparam int SW = sh_width(N, K)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [K-1:0]  out_m,
    output logic [SW-1:0] out_sh,
    output logic          out_zero
);

    localparam int PW = $clog2(N);

    // Stage 1 state
    logic          s1_valid;
    logic [N-1:0]  s1_a;
    logic [PW-1:0] s1_p;
    logic          s1_zero;

    // Leading-one detector on the incoming operand
    logic [PW-1:0] lod_p;
    logic          lod_zero;

    // Stage 2 next-value terms
    logic [K-1:0]  m_c;
    logic [SW-1:0] sh_c;
    logic          zero_c;
    logic [N-1:0]  shifted;

    logic s2_load;
    logic in_xfer;

    drum_lod #(.N(N)) u_lod (
        .a    (in_a),
        .p    (lod_p),
        .zero (lod_zero)
    );

    // Stage 2 takes new data when it is empty or its result leaves this cycle;
    // stage 1 can accept when empty or when stage 2 drains it. The ready path
    // is combinational from out_ready (no skid buffer).
    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign in_xfer  = in_valid && in_ready;

    // Stage 1: capture operand with its leading-one position and zero flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_p     <= '0;
            s1_zero  <= 1'b0;
        end else if (in_ready) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            s1_valid <= in_valid;
            if (in_xfer) begin
                s1_a    <= in_a;
                s1_p    <= lod_p;
                s1_zero <= lod_zero;
            end
        end
    end

    // Stage 2 datapath: exact pass-through for small operands, otherwise
    // shift the leading one to bit K-1 and force the LSB for unbiasing.
    always_comb begin
        m_c     = '0;
        sh_c    = '0;
        zero_c  = 1'b0;
        shifted = '0;
        if (s1_zero) begin
            zero_c = 1'b1;
        end else if (int'(s1_p) < K) begin
            m_c = s1_a[K-1:0];
        end else begin
            sh_c    = SW'(int'(s1_p) - K + 1);
            shifted = s1_a >> sh_c;
            m_c     = {shifted[K-1:1], 1'b1};
        end
    end

    // Stage 2: register the result; hold it while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_m     <= '0;
            out_sh    <= '0;
            out_zero  <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_m    <= m_c;
                out_sh   <= sh_c;
                out_zero <= zero_c;
            end
        end
    end

endmodule

// File: doc/drum_operand_truncator.md
Name: drum_operand_truncator

Overview:
- Input-side counterpart of the DRUM output left-shifter: it takes an N-bit unsigned operand, finds the leading one, and right-shifts the operand down to a K-bit approximate mantissa.
- The K-bit mantissa has its LSB forced to 1 for unbiasing. The block also returns the shift amount that the output stage later applies as a left shift.
- Implemented as a 2-stage valid/ready pipeline. One instance sits in front of each operand port of the DRUM multiplier core.

Parameters:
- N, 8, operand width in bits (N >= 4).
- K, 4, truncated mantissa width (2 <= K < N).
- SW, $clog2(N-K+1), shift-amount width. Localparam, derived from N and K, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block accepts the operand this cycle.
- in_a  input  N  unsigned operand.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_m  output  K  approximate mantissa.
- out_sh  output  SW  right-shift amount applied; the downstream left-shift restores it.
- out_zero  output  1  operand was zero.

Behaviour:
- Reset (rst high at a clk edge): stage valids clear. out_valid=0, out_m=0, out_sh=0, out_zero=0. in_ready is 1 in the cycle after reset.
- Reset mid-operation: all in-flight operands are discarded without being emitted.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - in_valid must not depend on in_ready. out_* stay stable while out_valid && !out_ready.
- Stage 1 (leading-one detect):
  - Registers the operand, p = index of the highest set bit (0..N-1), and a zero flag.
  - s1 loads whenever it is empty or stage 2 is taking its contents this cycle.
- Stage 2 (shift/round), registered into out_*:
  - if zero: m=0, sh=0, zero=1.
  - else if p < K: m = a[K-1:0], sh=0, zero=0. This case is exact, with no LSB forcing.
  - else: sh = p-K+1; m = (a >> sh) with bit 0 forced to 1; zero=0. Bit K-1 of m is always 1 in this case.
  - s2 loads when it is empty or out_ready=1.
- Handshake and throughput:
  - in_ready = !s1_valid || s2 accepts s1 this cycle. This is combinational from out_ready through the stage chain; no skid buffer.
  - Latency is exactly 2 cycles from input transfer to out_valid with no backpressure.
  - Throughput is 1 operand/cycle with out_ready held high.
- Simultaneous events: with both stages full and out_ready=1, all three transfers (in, s1->s2, s2->out) happen in the same cycle.
- Backpressure: with out_ready=0, at most 2 operands are held. in_ready drops once both stages are full.
- Reconstruction: a ≈ m << sh. No error flag; truncation error is by design.

Decomposition:
- Shared package drum_pkg:
  - constants N_DEF=8, K_DEF=4;
  - function for shift width, clog2(N-K+1);
  - typedef for the {m, sh, zero} result struct, reused by the multiplier core and the output shifter.
- Sub-module: drum_lod, a combinational leading-one detector producing p[$clog2(N)-1:0] and a zero flag, parameterised by N. Instantiated in stage 1.
- The shift/force-LSB logic stays inline in stage 2.

Test Plan:
- Reset, then in_a=8'd182 (1011_0110) -> 2 cycles later out_m=4'b1011, out_sh=4, out_zero=0.
- in_a=8'd13 (0000_1101) -> out_m=4'b1101, out_sh=0 (exact path, LSB not forced). in_a=8'd16 -> out_m=4'b1001, out_sh=1.
- in_a=0 -> out_zero=1, out_m=0, out_sh=0. in_a=8'd255 -> out_m=4'b1111, out_sh=4.
- Stream 182,13,16,255,0 back-to-back with out_ready=1 -> one result per cycle, in order, latency 2, in_ready constant 1.
- Stream 4 operands with out_ready=0 from cycle 1 -> in_ready=0 after 2 accepted; out_m/out_sh stable; on out_ready=1, all 4 emerge in order with none lost or duplicated.
- Assert rst while 2 operands are in flight -> next cycle out_valid=0, in_ready=1, and no stale result is emitted afterwards.
